// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/response handshake bundle for alu_exec_unit
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle integer execution unit, serial 1-bit/cycle shifter
// ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter instead.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_AUIPC = 4'b1000;
  localparam logic [3:0] OP_LUI   = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_SRL   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      imm_res;
  logic                 imm_ill;
  logic                 go_shift;
  logic [XLEN-1:0]      result_q;
  logic                 zero_q;
  logic                 illegal_q;

`ifndef ALU_BARREL_SHIFT_EN
  logic [3:0]           op_q;
  logic [XLEN-1:0]      work_q;
  logic [XLEN-1:0]      step_res;
  logic [SHAMT_W-1:0]   cnt_q;
`endif

  assign shamt = bus.src_b[SHAMT_W-1:0];

  // Single-cycle result; in the serial build this also covers shifts by zero.
  always_comb begin
    imm_res = '0;
    imm_ill = 1'b0;
    case (bus.alu_control)
      OP_ADD:   imm_res = bus.src_a + bus.src_b;
      OP_SUB:   imm_res = bus.src_a - bus.src_b;
      OP_AND:   imm_res = bus.src_a & bus.src_b;
      OP_OR:    imm_res = bus.src_a | bus.src_b;
      OP_XOR:   imm_res = bus.src_a ^ bus.src_b;
      OP_SLT:   imm_res = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      OP_SLTU:  imm_res = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
      OP_AUIPC: imm_res = bus.src_a + bus.src_b;
      OP_LUI:   imm_res = bus.src_b;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:   imm_res = bus.src_a << shamt;
      OP_SRA:   imm_res = $signed(bus.src_a) >>> shamt;
      OP_SRL:   imm_res = bus.src_a >> shamt;
`else
      OP_SLL, OP_SRA, OP_SRL: imm_res = bus.src_a;
`endif
      default:  imm_ill = 1'b1;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = ((bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRA) ||
                     (bus.alu_control == OP_SRL)) && (shamt != '0);

  always_comb begin
    case (op_q)
      OP_SLL:  step_res = {work_q[XLEN-2:0], 1'b0};
      OP_SRA:  step_res = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: step_res = {1'b0, work_q[XLEN-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = go_shift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
        if (cnt_q == SHAMT_W'(1)) begin
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = result_q;
    bus.zero      = zero_q;
    bus.illegal   = illegal_q;
  end

  // Result/flags change only on accept or on the final shift step, so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      op_q      <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (!go_shift) begin
              result_q  <= imm_res;
              zero_q    <= (imm_res == '0);
              illegal_q <= imm_ill;
            end
`ifndef ALU_BARREL_SHIFT_EN
            op_q   <= bus.alu_control;
            work_q <= bus.src_a;
            cnt_q  <= shamt;
`endif
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        SHIFT: begin
          work_q <= step_res;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q  <= step_res;
            zero_q    <= (step_res == '0);
            illegal_q <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed vector table plus corner sequences and random stream for alu_exec_unit
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus_if ();

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  logic [31:0] got_res;
  logic        got_z;
  logic        got_ill;
  int          got_lat;
  int          exp_lat;
  int          done_cnt;
  int          cyc;
  int          w;
  logic [3:0]  r_ctl;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    r   = 32'h0;
    ill = 1'b0;
    case (ctl)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    r = (a < b) ? 32'd1 : 32'd0;
      4'd8:    r = a + b;
      4'd9:    r = b;
      4'd10:   r = a << b[4:0];
      4'd11:   r = $signed(a) >>> b[4:0];
      4'd12:   r = a >> b[4:0];
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  task automatic run_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic ill, output int lat);
    int wt;
    @(negedge clk);
    bus_if.alu_control = ctl;
    bus_if.src_a       = a;
    bus_if.src_b       = b;
    bus_if.in_valid    = 1'b1;
    wt = 0;
    while (!bus_if.in_ready && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus_if.result;
    z   = bus_if.zero;
    ill = bus_if.illegal;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'h3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'h4, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'hB, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 5};
    vecs[8]  = '{4'hC, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5};
    vecs[9]  = '{4'hA, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32};
    vecs[10] = '{4'hA, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1};
    vecs[11] = '{4'hF, 32'h12345678, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1};
    vecs[12] = '{4'h7, 32'hDEADBEEF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1};
    vecs[13] = '{4'hB, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0, 5};
    vecs[14] = '{4'h9, 32'hAAAAAAAA, 32'h12345000, 32'h12345000, 1'b0, 1'b0, 1};
    vecs[15] = '{4'h8, 32'h00001000, 32'h00002000, 32'h00003000, 1'b0, 1'b0, 1};

    bus_if.in_valid    = 1'b0;
    bus_if.out_ready   = 1'b0;
    bus_if.alu_control = 4'h0;
    bus_if.src_a       = 32'h0;
    bus_if.src_b       = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_result",    bus_if.result,         32'h0);
    check("rst_zero",      32'(bus_if.zero),      32'd1);
    check("rst_illegal",   32'(bus_if.illegal),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus_if.in_ready),  32'd1);
    check("idle_out_valid", 32'(bus_if.out_valid), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, got_res, got_z, got_ill, got_lat);
`ifdef ALU_BARREL_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = vecs[i].lat;
`endif
      check($sformatf("vec%0d_result", i),  got_res,       vecs[i].res);
      check($sformatf("vec%0d_zero", i),    32'(got_z),    32'(vecs[i].z));
      check($sformatf("vec%0d_illegal", i), 32'(got_ill),  32'(vecs[i].ill));
      check($sformatf("vec%0d_latency", i), 32'(got_lat),  32'(exp_lat));
    end

    // Asynchronous reset in the middle of a long operation.
    @(negedge clk);
    bus_if.alu_control = 4'hA;
    bus_if.src_a       = 32'h1;
    bus_if.src_b       = 32'd20;
    bus_if.in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
`ifndef ALU_BARREL_SHIFT_EN
    check("midshift_busy", 32'(bus_if.in_ready), 32'd0);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(bus_if.in_ready),  32'd1);
    check("arst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("arst_result",    bus_if.result,         32'h0);
    check("arst_zero",      32'(bus_if.zero),      32'd1);
    check("arst_illegal",   32'(bus_if.illegal),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("arst_discarded", 32'(bus_if.out_valid), 32'd0);
    end

    // Backpressure: illegal op held for 10 cycles while new requests are offered.
    @(negedge clk);
    bus_if.alu_control = 4'hE;
    bus_if.src_a       = 32'h00001234;
    bus_if.src_b       = 32'h5;
    bus_if.in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("bp_valid_lat1", 32'(bus_if.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_if.in_valid    = 1'b1;
      bus_if.alu_control = 4'h0;
      bus_if.src_a       = 32'd7 + 32'(i);
      bus_if.src_b       = 32'd8;
      check("bp_result", bus_if.result, 32'h0);
      check("bp_flags", {28'h0, bus_if.out_valid, bus_if.in_ready, bus_if.zero, bus_if.illegal}, 32'hB);
    end
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("bp_release_ready", 32'(bus_if.in_ready),  32'd1);
    check("bp_release_valid", 32'(bus_if.out_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("bp_ignored_op", 32'(bus_if.out_valid), 32'd0);
    end

    // Random stream with random backpressure.
    done_cnt = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) begin
            bus_if.in_valid = 1'b0;
            @(negedge clk);
          end
          r_ctl = 4'($urandom_range(0, 15));
          r_a   = $urandom;
          r_b   = $urandom;
          bus_if.alu_control = r_ctl;
          bus_if.src_a       = r_a;
          bus_if.src_b       = r_b;
          bus_if.in_valid    = 1'b1;
          w = 0;
          while (!bus_if.in_ready && w < 300) begin
            @(negedge clk);
            w++;
          end
          if (!bus_if.in_ready) begin
            check("rnd_accept_timeout", 32'd0, 32'd1);
            break;
          end
          check("rnd_no_accept_while_valid", 32'(bus_if.out_valid), 32'd0);
          exp_q.push_back(model(r_ctl, r_a, r_b));
          @(posedge clk);
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
      end
      begin
        cyc = 0;
        while (done_cnt < 1000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          bus_if.out_ready = 1'($urandom_range(0, 1));
          if (bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
              check("rnd_unexpected_result", 32'd1, 32'd0);
            end else begin
              exp_e = exp_q.pop_front();
              check("rnd_result", bus_if.result, exp_e[31:0]);
              check("rnd_flags", {30'h0, bus_if.illegal, bus_if.zero},
                    {30'h0, exp_e[32], (exp_e[31:0] == 32'h0)});
            end
            done_cnt++;
          end
        end
        bus_if.out_ready = 1'b0;
      end
    join
    check("rnd_completed", 32'(done_cnt), 32'd1000);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
